// File: rtl/game_pkg.sv
// Shared definitions for the game mode controller: one-hot state encodings and key indices.
package game_pkg;

  localparam int unsigned StateW  = 4;
  localparam int unsigned NumKeys = 5;
  localparam int unsigned FrameCntW = 10;

  typedef enum logic [StateW-1:0] {
    StStart = 4'b0001,
    StPlay  = 4'b0010,
    StPause = 4'b0100,
    StEnd   = 4'b1000
  } state_e;

  // Bit positions inside the packed key vector.
  localparam int unsigned KeyLeft  = 0;
  localparam int unsigned KeyRight = 1;
  localparam int unsigned KeyUp    = 2;
  localparam int unsigned KeyDown  = 3;
  localparam int unsigned KeyPause = 4;

endpackage

// File: rtl/key_edge.sv
// Key event generator: rising-edge detect or pass-through of debounced key levels.
module key_edge #(
  parameter int unsigned N        = 5,
  parameter int unsigned KEY_EDGE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_ev
);

  logic [N-1:0] key_d_q;

  // Reset to all ones so keys held through reset do not fire on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_d_q <= '1;
    end else begin
      key_d_q <= key;
    end
  end

  always_comb begin
    key_ev = key;
    if (KEY_EDGE != 0) begin
      key_ev = key & ~key_d_q;
    end
  end

endmodule

// File: rtl/game_mode_ctrl.sv
// Game mode FSM (start/play/pause/end) with frame-aligned video source selection.
module game_mode_ctrl
  import game_pkg::*;
#(
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned END_FRAMES = 180,
  parameter int unsigned KEY_EDGE   = 1,
  parameter logic        SYNC_IDLE  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_pause,
  input  logic               hit_wall,
  input  logic               hit_body,
  input  logic               frame_start,
  input  logic [COLOR_W-1:0] start_vga_r,
  input  logic [COLOR_W-1:0] start_vga_g,
  input  logic [COLOR_W-1:0] start_vga_b,
  input  logic [COLOR_W-1:0] play_vga_r,
  input  logic [COLOR_W-1:0] play_vga_g,
  input  logic [COLOR_W-1:0] play_vga_b,
  input  logic [COLOR_W-1:0] end_vga_r,
  input  logic [COLOR_W-1:0] end_vga_g,
  input  logic [COLOR_W-1:0] end_vga_b,
  input  logic               start_hs,
  input  logic               start_vs,
  input  logic               play_hs,
  input  logic               play_vs,
  input  logic               end_hs,
  input  logic               end_vs,
  output logic [3:0]         game_status,
  output logic               play_en,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hs,
  output logic               vga_vs
);

  localparam logic [FrameCntW-1:0] EndLast = FrameCntW'(END_FRAMES - 1);

  state_e               state_q, state_d;
  state_e               disp_sel_q;
  logic [FrameCntW-1:0] frame_cnt_q, frame_cnt_d;
  logic [NumKeys-1:0]   key_ev;
  logic                 dir_ev, pause_ev, start_ev, hit;

  logic [COLOR_W-1:0] vga_r_d, vga_g_d, vga_b_d;
  logic               vga_hs_d, vga_vs_d;
  logic [COLOR_W-1:0] vga_r_q, vga_g_q, vga_b_q;
  logic               vga_hs_q, vga_vs_q;

  key_edge #(
    .N        (NumKeys),
    .KEY_EDGE (KEY_EDGE)
  ) u_key_edge (
    .clk    (clk),
    .rst    (rst),
    .key    ({key_pause, key_down, key_up, key_right, key_left}),
    .key_ev (key_ev)
  );

  assign dir_ev   = |key_ev[KeyDown:KeyLeft];
  assign pause_ev = key_ev[KeyPause];
  // Left is deliberately not a start key.
  assign start_ev = key_ev[KeyRight] | key_ev[KeyUp] | key_ev[KeyDown];
  assign hit      = hit_wall | hit_body;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStart: if (start_ev) state_d = StPlay;
      StPlay: begin
        if (hit) begin
          state_d = StEnd;
        end else if (pause_ev) begin
          state_d = StPause;
        end
      end
      StPause: if (pause_ev) state_d = StPlay;
      StEnd: begin
        if (dir_ev || pause_ev || (frame_start && frame_cnt_q == EndLast)) begin
          state_d = StStart;
        end
      end
      default: state_d = StStart;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q != StEnd && state_d == StEnd) begin
      frame_cnt_d = '0;
    end else if (state_q == StEnd && frame_start && frame_cnt_q != '1) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_comb begin
    vga_r_d  = start_vga_r;
    vga_g_d  = start_vga_g;
    vga_b_d  = start_vga_b;
    vga_hs_d = start_hs;
    vga_vs_d = start_vs;
    unique case (disp_sel_q)
      StPlay: begin
        vga_r_d  = play_vga_r;
        vga_g_d  = play_vga_g;
        vga_b_d  = play_vga_b;
        vga_hs_d = play_hs;
        vga_vs_d = play_vs;
      end
      StPause: begin
        vga_r_d  = play_vga_r >> 1;
        vga_g_d  = play_vga_g >> 1;
        vga_b_d  = play_vga_b >> 1;
        vga_hs_d = play_hs;
        vga_vs_d = play_vs;
      end
      StEnd: begin
        vga_r_d  = end_vga_r;
        vga_g_d  = end_vga_g;
        vga_b_d  = end_vga_b;
        vga_hs_d = end_hs;
        vga_vs_d = end_vs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StStart;
      disp_sel_q  <= StStart;
      frame_cnt_q <= '0;
      vga_r_q     <= '0;
      vga_g_q     <= '0;
      vga_b_q     <= '0;
      vga_hs_q    <= SYNC_IDLE;
      vga_vs_q    <= SYNC_IDLE;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      // Screen source only changes at frame boundaries to avoid tearing.
      if (frame_start) begin
        disp_sel_q <= state_q;
      end
      vga_r_q  <= vga_r_d;
      vga_g_q  <= vga_g_d;
      vga_b_q  <= vga_b_d;
      vga_hs_q <= vga_hs_d;
      vga_vs_q <= vga_vs_d;
    end
  end

  assign game_status = state_q;
  assign play_en     = (state_q == StPlay);
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Scoreboard bench for game_mode_ctrl: directed scenarios plus random traffic vs a reference model.
module tb_game_mode_ctrl;
  import game_pkg::*;

  localparam int CW = 8;
  localparam int EF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [4:0]    keys = '0;  // left, right, up, down, pause
  logic          hit_wall = 1'b0, hit_body = 1'b0, frame_start = 1'b0;
  logic [CW-1:0] s_r = '0, s_g = '0, s_b = '0, p_r = '0, p_g = '0, p_b = '0;
  logic [CW-1:0] e_r = '0, e_g = '0, e_b = '0;
  logic          s_hs = 1'b0, s_vs = 1'b0, p_hs = 1'b0, p_vs = 1'b0, e_hs = 1'b0, e_vs = 1'b0;
  logic [3:0]    game_status;
  logic          play_en;
  logic [CW-1:0] vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs;

  game_mode_ctrl #(
    .COLOR_W    (CW),
    .END_FRAMES (EF),
    .KEY_EDGE   (1),
    .SYNC_IDLE  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_left    (keys[0]),
    .key_right   (keys[1]),
    .key_up      (keys[2]),
    .key_down    (keys[3]),
    .key_pause   (keys[4]),
    .hit_wall    (hit_wall),
    .hit_body    (hit_body),
    .frame_start (frame_start),
    .start_vga_r (s_r),
    .start_vga_g (s_g),
    .start_vga_b (s_b),
    .play_vga_r  (p_r),
    .play_vga_g  (p_g),
    .play_vga_b  (p_b),
    .end_vga_r   (e_r),
    .end_vga_g   (e_g),
    .end_vga_b   (e_b),
    .start_hs    (s_hs),
    .start_vs    (s_vs),
    .play_hs     (p_hs),
    .play_vs     (p_vs),
    .end_hs      (e_hs),
    .end_vs      (e_vs),
    .game_status (game_status),
    .play_en     (play_en),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs)
  );

  typedef struct {
    logic [3:0]    gs;
    logic          pe;
    logic [CW-1:0] r, g, b;
    logic          hs, vs;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   hold_col = 1'b1;

  // Reference model: mode index 0=start 1=play 2=pause 3=end.
  int            m_mode = 0;
  int            m_sel  = 0;
  int            m_frames = 0;
  logic [4:0]    m_prev = '1;
  logic [CW-1:0] m_r = '0, m_g = '0, m_b = '0;
  logic          m_hs = 1'b1, m_vs = 1'b1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  task automatic model_update();
    logic [4:0] ev;
    int         nxt;
    exp_t       e;
    if (rst) begin
      m_mode = 0; m_sel = 0; m_frames = 0; m_prev = '1;
      m_r = '0; m_g = '0; m_b = '0; m_hs = 1'b1; m_vs = 1'b1;
    end else begin
      ev  = keys & ~m_prev;
      nxt = m_mode;
      case (m_mode)
        0: if (ev[1] || ev[2] || ev[3]) nxt = 1;
        1: if (hit_wall || hit_body) nxt = 3; else if (ev[4]) nxt = 2;
        2: if (ev[4]) nxt = 1;
        default: if (ev != 0 || (frame_start && m_frames == EF - 1)) nxt = 0;
      endcase
      case (m_sel)
        0: begin m_r = s_r; m_g = s_g; m_b = s_b; m_hs = s_hs; m_vs = s_vs; end
        1: begin m_r = p_r; m_g = p_g; m_b = p_b; m_hs = p_hs; m_vs = p_vs; end
        2: begin
          m_r = CW'(p_r / 2); m_g = CW'(p_g / 2); m_b = CW'(p_b / 2);
          m_hs = p_hs; m_vs = p_vs;
        end
        default: begin m_r = e_r; m_g = e_g; m_b = e_b; m_hs = e_hs; m_vs = e_vs; end
      endcase
      if (frame_start) m_sel = m_mode;
      if (m_mode != 3 && nxt == 3) m_frames = 0;
      else if (m_mode == 3 && frame_start && m_frames < 1023) m_frames++;
      m_mode = nxt;
      m_prev = keys;
    end
    e.gs = 4'(1 << m_mode);
    e.pe = (m_mode == 1);
    e.r = m_r; e.g = m_g; e.b = m_b; e.hs = m_hs; e.vs = m_vs;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [4:0] k, input logic hw, input logic hb, input logic fs,
                      input logic r);
    @(negedge clk);
    keys = k; hit_wall = hw; hit_body = hb; frame_start = fs; rst = r;
    if (!hold_col) begin
      {s_r, s_g, s_b} = 24'($urandom);
      {p_r, p_g, p_b} = 24'($urandom);
      {e_r, e_g, e_b} = 24'($urandom);
      {s_hs, s_vs, p_hs, p_vs, e_hs, e_vs} = 6'($urandom);
    end
    model_update();
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs with the oldest expectation after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_game_status", 32'(game_status), 32'(e.gs));
      chk("sb_play_en", 32'(play_en), 32'(e.pe));
      chk("sb_vga_rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, e.r, e.g, e.b});
      chk("sb_vga_sync", {30'h0, vga_hs, vga_vs}, {30'h0, e.hs, e.vs});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] kr;
    s_r = 8'h11; p_r = 8'hFE; e_r = 8'h33;
    s_g = 8'h22; p_g = 8'h81; e_g = 8'h44;
    s_b = 8'h55; p_b = 8'h03; e_b = 8'h66;

    // Reset state
    step(5'h00, 0, 0, 0, 1);
    step(5'h00, 0, 0, 0, 1);
    sample();
    chk("reset_status", 32'(game_status), 32'h1);
    chk("reset_vga_r", 32'(vga_r), 32'h0);
    chk("reset_sync", {30'h0, vga_hs, vga_vs}, 32'h3);

    // Start via right key; video follows only after a frame boundary
    step(5'h00, 0, 0, 0, 0);
    step(5'h02, 0, 0, 0, 0);
    sample();
    chk("right_to_play", 32'(game_status), 32'h2);
    chk("play_en_high", 32'(play_en), 32'h1);
    step(5'h00, 0, 0, 1, 0);
    sample();
    chk("vga_still_start", 32'(vga_r), 32'h11);
    step(5'h00, 0, 0, 0, 0);
    sample();
    chk("vga_play_src", 32'(vga_r), 32'hFE);

    // Pause dims play colours, second pause resumes
    step(5'h10, 0, 0, 0, 0);
    sample();
    chk("pause_status", 32'(game_status), 32'h4);
    chk("pause_play_en", 32'(play_en), 32'h0);
    step(5'h00, 0, 0, 1, 0);
    step(5'h00, 0, 0, 0, 0);
    sample();
    chk("pause_half_r", 32'(vga_r), 32'h7F);
    step(5'h10, 0, 0, 0, 0);
    sample();
    chk("resume_play", 32'(game_status), 32'h2);

    // Collision beats simultaneous pause
    step(5'h00, 0, 0, 0, 0);
    step(5'h10, 1, 0, 0, 0);
    sample();
    chk("hit_over_pause", 32'(game_status), 32'h8);

    // End screen times out on the third frame
    step(5'h00, 0, 0, 1, 0);
    step(5'h00, 0, 0, 0, 0);
    step(5'h00, 0, 0, 1, 0);
    sample();
    chk("end_hold_2frames", 32'(game_status), 32'h8);
    step(5'h00, 0, 0, 0, 0);
    step(5'h00, 0, 0, 1, 0);
    sample();
    chk("end_timeout", 32'(game_status), 32'h1);

    // Key held through reset release produces no event
    step(5'h04, 0, 0, 0, 1);
    step(5'h04, 0, 0, 0, 1);
    step(5'h04, 0, 0, 0, 0);
    step(5'h04, 0, 0, 0, 0);
    sample();
    chk("held_key_ignored", 32'(game_status), 32'h1);
    step(5'h00, 0, 0, 0, 0);
    step(5'h04, 0, 0, 0, 0);
    sample();
    chk("up_reedge_play", 32'(game_status), 32'h2);

    // Reset during pause
    step(5'h00, 0, 0, 0, 0);
    step(5'h10, 0, 0, 0, 0);
    step(5'h00, 0, 0, 1, 0);
    step(5'h00, 0, 0, 0, 0);
    step(5'h00, 0, 0, 0, 1);
    sample();
    chk("rst_pause_status", 32'(game_status), 32'h1);
    chk("rst_pause_play_en", 32'(play_en), 32'h0);
    chk("rst_pause_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    chk("rst_pause_sync", {30'h0, vga_hs, vga_vs}, 32'h3);
    step(5'h00, 0, 0, 0, 0);

    // Random traffic
    hold_col = 1'b0;
    kr = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(5) == 0) kr[b] = ~kr[b];
      end
      step(kr, ($urandom_range(19) == 0), ($urandom_range(19) == 0),
           ($urandom_range(3) == 0), ($urandom_range(199) == 0));
    end

    // Illegal state recovery
    step(5'h00, 0, 0, 0, 1);
    step(5'h00, 0, 0, 0, 0);
    step(5'h02, 0, 0, 0, 0);
    sample();
    chk("pre_force_play", 32'(game_status), 32'h2);
    @(negedge clk);
    keys = '0;
    force dut.state_q = state_e'(4'b0110);
    @(posedge clk);
    #1;
    chk("forced_next_start", 32'(dut.state_d), 32'h1);
    @(negedge clk);
    release dut.state_q;
    sample();
    chk("illegal_to_start", 32'(game_status), 32'h1);
    if (sbq.size() != 0) chk("sb_drained", 32'(sbq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_mode_ctrl.md
GAME_MODE_CTRL -- requirements
Module: game_mode_ctrl

Interface
REQ-001 SHALL have parameter COLOR_W, default 8: bits per colour channel.
REQ-002 SHALL have parameter END_FRAMES, default 180: END-screen frames before automatic return to START (range 1..1023).
REQ-003 SHALL have parameter KEY_EDGE, default 1: 1 = keys act on rising edge, 0 = keys act on level.
REQ-004 SHALL have parameter SYNC_IDLE, default 1'b1: inactive level of hs/vs.
REQ-005 SHALL have port clk, input, 1: single clock domain.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have ports key_left/key_right/key_up/key_down/key_pause, input, 1 each: debounced key levels.
REQ-008 SHALL have ports hit_wall/hit_body, input, 1 each: collision flags from play logic.
REQ-009 SHALL have port frame_start, input, 1: one-cycle pulse at the start of each video frame.
REQ-010 SHALL have ports {start,play,end}_vga_{r,g,b}, input, COLOR_W each: source colours.
REQ-011 SHALL have ports {start,play,end}_{hs,vs}, input, 1 each: source syncs.
REQ-012 SHALL have port game_status, output, 4: one-hot state.
REQ-013 SHALL have port play_en, output, 1: high only in PLAY; freezes snake logic otherwise.
REQ-014 SHALL have ports vga_r/vga_g/vga_b, output, COLOR_W each, and vga_hs/vga_vs, output, 1 each: registered video outputs.

Function
REQ-015 SHALL encode states START=0001, PLAY=0010, PAUSE=0100, END=1000; game_status equals the state register.
REQ-016 SHALL derive key events as key & ~key_d (key_d is the previous-cycle level) when KEY_EDGE=1, and as raw key level when KEY_EDGE=0.
REQ-017 START: a right/up/down event SHALL move to PLAY next cycle; left and pause events SHALL be ignored.
REQ-018 PLAY: hit_wall|hit_body SHALL move to END, taking priority over a simultaneous pause event; otherwise a pause event SHALL move to PAUSE.
REQ-019 PAUSE: a pause event SHALL return to PLAY; direction keys, hit_wall and hit_body SHALL be ignored.
REQ-020 END: any direction or pause event SHALL move to START; otherwise the state SHALL move to START when frame_cnt reaches END_FRAMES-1 and frame_start is high.
REQ-021 frame_cnt SHALL be 10 bits, clear to 0 on entry to END, increment on each frame_start while in END, and never wrap.
REQ-022 Any non-one-hot state value SHALL move to START next cycle.
REQ-023 disp_sel SHALL copy the state only on cycles where frame_start=1, so screen changes are frame-aligned; between frames the previous source is held.
REQ-024 Video outputs SHALL be registered with 1-cycle latency from the selected inputs.
REQ-025 disp_sel=START SHALL select the start sources; disp_sel=END SHALL select the end sources; disp_sel=PLAY SHALL select the play sources.
REQ-026 disp_sel=PAUSE SHALL output the play colours shifted right by 1 (half brightness, zero fill) and the play syncs unchanged.
REQ-027 play_en SHALL be combinational from the state (not disp_sel), so it changes in the same cycle as game_status.

Reset
REQ-028 On rst, the state SHALL be START, disp_sel START, frame_cnt 0, all key_d 1 (keys held through reset generate no event), vga_r/g/b 0, and vga_hs/vga_vs SYNC_IDLE.
REQ-029 Reset asserted mid-game SHALL take effect on the next clk edge, whatever the state or frame phase.

Structure
REQ-030 The state encodings and the 4-bit state type SHALL live in the shared package game_pkg.
REQ-031 Key edge detection SHALL be a sub-module key_edge, parametrised by key count N=5 and by KEY_EDGE.

Verification
REQ-032 Directed test: reset, then key_right pulse -> game_status 0010 next cycle and play_en 1; vga output switches to the play source only after the next frame_start, plus 1 cycle.
REQ-033 Directed test: in PLAY, hit_wall and a key_pause edge in the same cycle -> END (1000), not PAUSE.
REQ-034 Directed test: in PLAY, key_pause edge, then play_vga_r=8'hFE -> vga_r=8'h7F after the next frame_start; a second pause edge -> PLAY.
REQ-035 Directed test: END with no keys and END_FRAMES=3 -> START on the 3rd frame_start after entry.
REQ-036 Directed test: key_up held through reset release -> the state stays START until key_up falls and rises again (KEY_EDGE=1).
REQ-037 Directed test: force the state to 0110 -> START next cycle; assert rst during PAUSE -> all outputs at their REQ-028 reset values next cycle.
